// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin req/ack arbiter that shares one memory port between two requesters.
// Each transaction gets one ACCESS cycle; read data is registered back on a one-cycle ack.
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic owner, owner_nx, last, last_nx, elig0, elig1, win, grant, access;
  // In RESP the owner's req still belongs to the finished transaction, so only the other side may win
  always_comb begin
    access   = state == ACCESS;
    elig0    = r0_req && (state == IDLE || (state == RESP && owner));
    elig1    = r1_req && (state == IDLE || (state == RESP && !owner));
    win      = (elig0 && elig1) ? !last : elig1;
    grant    = !access && (elig0 || elig1);
    state_nx = access ? RESP : (grant ? ACCESS : IDLE);
    owner_nx = grant ? win : owner;
    last_nx  = grant ? win : last;
    mem_we    = access && (owner ? r1_we : r0_we);
    mem_addr  = access ? (owner ? r1_addr : r0_addr) : '0;
    mem_wdata = access ? (owner ? r1_wdata : r0_wdata) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      r0_ack <= access && !owner;
      r1_ack <= access && owner;
      if (access && !owner) r0_rdata <= mem_rdata;
      if (access && owner) r1_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench; expected read data comes from a plain reference memory array.
module tb_data_mem_arbiter;
  typedef struct {logic [7:0] rd; logic we; logic [7:0] a; logic [7:0] d; int c;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req, we, ack;
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  bit [7:0] mem [256];
  bit [7:0] ref_mem [256];
  exp_t q0[$], q1[$];
  int order[$], order_cyc[$];
  int ack_cyc [2], lat_last [2];
  int cyc = 0, errors = 0, checks = 0;
  logic [1:0] p_ack;
  logic p_we;
  logic [7:0] p_addr, p_wd;
  logic [7:0] p_rd [2];
  logic [7:0] r0_saved;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_ack(ack[0]), .r0_rdata(rdata[0]),
    .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_ack(ack[1]), .r1_rdata(rdata[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", n, got, want, cyc);
    end
  endtask

  task automatic chk_ack(input int r, input exp_t e);
    chk(r == 0 ? "r0_rdata" : "r1_rdata", rdata[r], e.rd);
    chk("access_we", p_we, e.we);
    chk("access_addr", p_addr, e.a);
    chk("access_wdata", p_wd, e.d);
    chk("latency_min2", cyc - e.c >= 2, 1);
    chk("latency_max5", cyc - e.c <= 5, 1);
    chk("resp_mem_quiet", {mem_we, mem_addr, mem_wdata}, 0);
    ack_cyc[r] = cyc;
    lat_last[r] = cyc - e.c;
    order.push_back(r);
    order_cyc.push_back(cyc);
  endtask

  task automatic issue_exp(input int r, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rd);
    exp_t e;
    e = '{rd, w, a, d, cyc};
    if (r == 0) q0.push_back(e); else q1.push_back(e);
    we[r] = w;
    addr[r] = a;
    wdata[r] = d;
    req[r] = 1'b1;
    for (int k = 0; k < 8 && !ack[r]; k++) @(negedge clk);
    chk(r == 0 ? "r0_ack_timeout" : "r1_ack_timeout", ack[r], 1);
    @(posedge clk);
    #1;
    req[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    rd = ref_mem[a];
    if (w) ref_mem[a] = d;
    issue_exp(r, w, a, d, rd);
  endtask

  task automatic run(input int r, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      issue(r, 1'($urandom_range(0, 1)), 8'(r * 128 + $urandom_range(0, 127)), 8'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = '0;
    we = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
    #1 reset = 1'b1;
    fork
      begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          chk("ack_exclusive", ack[0] & ack[1], 0);
          chk("r0_ack_width", ack[0] & p_ack[0], 0);
          chk("r1_ack_width", ack[1] & p_ack[1], 0);
          if (ack[0]) begin
            if (q0.size() > 0) chk_ack(0, q0.pop_front());
            else begin checks++; errors++; $display("FAIL r0_spurious_ack: ack=1, required 0 (nothing outstanding)"); end
          end else chk("r0_rdata_hold", rdata[0], p_rd[0]);
          if (ack[1]) begin
            if (q1.size() > 0) chk_ack(1, q1.pop_front());
            else begin checks++; errors++; $display("FAIL r1_spurious_ack: ack=1, required 0 (nothing outstanding)"); end
          end else chk("r1_rdata_hold", rdata[1], p_rd[1]);
        end
        p_ack = ack;
        p_we = mem_we;
        p_addr = mem_addr;
        p_wd = mem_wdata;
        p_rd = rdata;
      end
    join_none
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_r0_rdata", rdata[0], 0);
    chk("rst_r1_rdata", rdata[1], 0);
    chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
    // single write then read-back
    issue(0, 1'b1, 8'h10, 8'hA5);
    chk("t1_latency", lat_last[0], 2);
    issue(0, 1'b0, 8'h10, 8'h5A);
    chk("t1_readback", rdata[0], 8'hA5);
    // simultaneous requests right after reset: r0 wins the first tie
    do_reset();
    ref_mem[8'h20] = 8'h3C;
    fork
      issue_exp(0, 1'b0, 8'h20, 8'h11, 8'h00);
      issue_exp(1, 1'b1, 8'h20, 8'h3C, 8'h00);
    join
    chk("tie_gap", ack_cyc[1] - ack_cyc[0], 2);
    issue(1, 1'b0, 8'h20, 8'h00);
    // continuous contention: strict alternation at one ack per two cycles
    order.delete();
    order_cyc.delete();
    fork
      run(0, 5, 0);
      run(1, 5, 0);
    join
    chk("alt_count", order.size(), 10);
    for (int i = 0; i < order.size(); i++) chk("alt_order", order[i], i % 2);
    if (order.size() == 10) chk("alt_span", order_cyc[9] - order_cyc[0], 18);
    // lone r1 back-to-back reads: three-cycle period
    r0_saved = rdata[0];
    order.delete();
    order_cyc.delete();
    for (int i = 0; i < 3; i++) issue(1, 1'b0, 8'(128 + $urandom_range(0, 127)), 8'($urandom));
    chk("single_count", order.size(), 3);
    for (int i = 1; i < order_cyc.size(); i++) chk("single_period", order_cyc[i] - order_cyc[i-1], 3);
    chk("single_r0_untouched", rdata[0], r0_saved);
    // asynchronous reset during the ACCESS cycle of an r1 write
    we[1] = 1'b1;
    addr[1] = 8'h40;
    wdata[1] = 8'hFF;
    req[1] = 1'b1;
    for (int k = 0; k < 4 && !mem_we; k++) @(negedge clk);
    chk("rst_mid_access_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_we_async", mem_we, 0);
    chk("rst_mid_addr_async", mem_addr, 0);
    req[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_ack", ack, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_no_ack", ack, 0);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 8'h40, 8'h00);
    chk("post_rst_idle_latency", lat_last[1], 2);
    // read-before-write on a write transaction
    issue(0, 1'b1, 8'h05, 8'h77);
    issue(0, 1'b1, 8'h05, 8'h88);
    chk("rbw_value", rdata[0], 8'h77);
    // randomized traffic with idle gaps; address halves keep the two streams independent
    fork
      run(0, 30, 2);
      run(1, 30, 2);
    join
    issue(0, 1'b0, 8'h05, 8'h00);
    repeat (4) @(posedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer for the 256 x 8 data memory: it shares the single memory port between requester 0 (execute unit) and requester 1 (program loader / debug port). It uses a req/ack handshake and round-robin fairness. Each transaction is presented to the memory for exactly one cycle. Read data is registered back to the winning requester.

## Interface
- ADDR_W, 8, address width (memory depth 2**ADDR_W)
- DATA_W, 8, data width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- r0_req / r1_req  in  1  transaction request, held until ack
- r0_we / r1_we  in  1  1 = write, 0 = read; stable while req high
- r0_addr / r1_addr  in  ADDR_W  address; stable while req high
- r0_wdata / r1_wdata  in  DATA_W  write data; stable while req high
- r0_ack / r1_ack  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DATA_W  registered read data, valid while ack high, held until that requester's next ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- State machine has three states: IDLE, ACCESS, RESP. Registers: state, owner (1 bit), last (1 bit, last requester served), r0/r1 ack and rdata.
- Arbitration set:
  - In IDLE, both requesters are eligible.
  - In RESP, only the non-owner is eligible. The owner's req is still high for the completed transaction and is ignored.
- Winner selection:
  - If one eligible req is high, that requester wins.
  - If both are high, the requester != last wins.
- IDLE -> ACCESS when any eligible req is high: owner <= winner, last <= winner. Otherwise stay in IDLE.
- ACCESS -> RESP, unconditionally:
  - owner's rdata <= mem_rdata
  - owner's ack <= 1 for the RESP cycle only
- RESP:
  - -> ACCESS if the non-owner's req is high, with owner <= non-owner and last <= non-owner.
  - -> IDLE otherwise.
- Memory drive is combinational from registered state:
  - In ACCESS: mem_addr/mem_wdata = owner's addr/wdata, mem_we = owner's we.
  - In all other states: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Writes commit at the edge ending ACCESS.
- A write transaction also returns rdata: the pre-write contents of the address (read-before-write).
- A requester drops req, or presents a new transaction, in the cycle after its ack. Re-asserting req in the ack cycle itself is not permitted.
- Reset values: state IDLE, owner 0, last 1 (so r0 wins the first tie), r0_ack = r1_ack = 0, r0_rdata = r1_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-operation:
  - If reset asserts during ACCESS, mem_we drops immediately (asynchronously), so no write is committed.
  - A pending ack is lost. Requesters must re-issue after reset.

## Timing
- Request latency: req sampled high in IDLE at edge t gives ACCESS in cycle t+1 and ack in cycle t+2. Minimum latency is 2 cycles.
- Sustained throughput is 1 transaction per 2 cycles under alternating contention, and 1 per 3 cycles for a single requester (it must go through IDLE).
- Ack is exactly one cycle wide. It is never asserted for both requesters in the same cycle.
- Starvation bound: a held req is acked within 4 cycles of being sampled, whatever the other requester does.
- No combinational path from any r*_req / r*_addr input to ack or rdata.

## Test plan
- Reset, then r0 write addr 0x10 data 0xA5 -> mem_we high only in the ACCESS cycle; r0_ack in cycle t+2; r0_rdata = 0x00. Then r0 read 0x10 -> r0_rdata = 0xA5.
- r0 and r1 both raise req in the same cycle after reset (r0 read 0x20, r1 write 0x20 data 0x3C) -> r0 acked first with 0x00; r1 ACCESS immediately follows RESP; r1 acked 2 cycles after r0; a subsequent read of 0x20 returns 0x3C.
- Both requesters hold continuous back-to-back requests for 20 cycles -> acks strictly alternate r0, r1, r0, ...; 10 acks total, 5 each; no cycle has both acks high.
- Single requester r1 issues back-to-back reads -> 3-cycle period, passing through IDLE; r1_rdata updates only on ack cycles; r0_rdata unchanged.
- Assert reset asynchronously (mid-cycle) during ACCESS of an r1 write to 0x40 data 0xFF -> mem_we falls immediately; no ack; state returns to IDLE; 0x40 is not written.
- Write 0x77 to 0x05, then write 0x88 to 0x05 -> second ack returns rdata 0x77 (read-before-write).
